result_parser: RTL and testbench

Serial decoder for the 8-nibble display format: it turns a formatted 32-bit word back into a signed 21-bit ALU result and an unsigned 21-bit remainder. It sits between result memory or a display buffer and the ALU operand path, so a stored result can be reloaded as an operand. A start/busy/done handshake scans one nibble per clock, from most significant to least significant, and accumulates the value by multiply-by-10-and-add.

---
 rtl/calcpkg.sv | 32 +++
 rtl/bcdaccumulator.sv | 45 ++++
 rtl/result_parser.sv | 198 +++++++++++++++++++
 tb/tb_result_parser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/calcpkg.sv
// Shared definitions for the calculator result path: nibble codes, widths,
// magnitude limits and the parser state/phase encodings.
package calcpkg;

  localparam int unsigned WIDTH     = 21;
  localparam int unsigned ACC_WIDTH = 24;

  localparam logic [3:0] DIG_R     = 4'hA;
  localparam logic [3:0] DIG_NEG   = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [ACC_WIDTH-1:0] LIMIT_POS = 24'd1048575;
  localparam logic [ACC_WIDTH-1:0] LIMIT_NEG = 24'd1048576;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    PhLead,
    PhSign,
    PhRes,
    PhRem
  } phase_e;

  function automatic logic is_digit(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcdaccumulator.sv
// Decimal accumulator: value = value * 10 + digit on each enable, with a sticky
// overflow flag that saturates once the value passes the limit or nears the top.
module bcdaccumulator
  import calcpkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [3:0]           digit,
  input  logic [ACC_WIDTH-1:0] limit,
  output logic [ACC_WIDTH-1:0] value,
  output logic                 overflow
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (enable) begin
      acc_d = (acc_q << 3) + (acc_q << 1) + {{(ACC_WIDTH-4){1'b0}}, digit};
      // Top two bits catch runaway values before they can wrap the accumulator.
      ovf_d = ovf_q | acc_d[ACC_WIDTH-1] | acc_d[ACC_WIDTH-2] | (acc_d > limit);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign value    = acc_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/result_parser.sv
// Serial parser turning an 8-nibble display word back into a signed result and
// an unsigned remainder; one nibble per clock, fixed 9-cycle latency.
module result_parser #(
  parameter int unsigned WIDTH = calcpkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      formatted,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             remain,
  output logic             error,
  output logic             busy,
  output logic             done
);

  import calcpkg::*;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [31:0]          shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 err_q, err_d;
  logic                 rem_dig_q, rem_dig_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 remain_q, remain_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 acc_clear, res_en, rem_en;
  logic [3:0]           nib;
  logic [ACC_WIDTH-1:0] res_mag, rem_mag, res_limit;
  logic                 res_ovf, rem_ovf;
  logic                 bad;
  logic [WIDTH-1:0]     res_abs;

  assign nib       = shift_q[31:28];
  assign res_limit = neg_q ? LIMIT_NEG : LIMIT_POS;

  bcdaccumulator u_res_acc (
    .clock    (clock),
    .reset    (reset),
    .clear    (acc_clear),
    .enable   (res_en),
    .digit    (nib),
    .limit    (res_limit),
    .value    (res_mag),
    .overflow (res_ovf)
  );

  bcdaccumulator u_rem_acc (
    .clock    (clock),
    .reset    (reset),
    .clear    (acc_clear),
    .enable   (rem_en),
    .digit    (nib),
    .limit    (LIMIT_POS),
    .value    (rem_mag),
    .overflow (rem_ovf)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    err_d       = err_q;
    rem_dig_d   = rem_dig_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    remain_d    = remain_q;
    error_d     = error_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    acc_clear   = 1'b0;
    res_en      = 1'b0;
    rem_en      = 1'b0;
    bad         = 1'b0;
    res_abs     = res_mag[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StScan;
          shift_d   = formatted;
          cnt_d     = 3'd0;
          phase_d   = PhLead;
          neg_d     = 1'b0;
          err_d     = 1'b0;
          rem_dig_d = 1'b0;
          acc_clear = 1'b1;
          busy_d    = 1'b1;
        end
      end

      StScan: begin
        shift_d = {shift_q[27:0], 4'h0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StFinish;
        end
        // Errors are sticky; the phase is simply held on an offending nibble.
        if (is_digit(nib)) begin
          if (phase_q == PhRem) begin
            rem_en    = 1'b1;
            rem_dig_d = 1'b1;
          end else begin
            res_en  = 1'b1;
            phase_d = PhRes;
          end
        end else begin
          case (nib)
            DIG_R: begin
              if (phase_q == PhRes) phase_d = PhRem;
              else                  err_d   = 1'b1;
            end
            DIG_NEG: begin
              if (phase_q == PhLead) begin
                phase_d = PhSign;
                neg_d   = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            DIG_BLANK: begin
              if (phase_q != PhLead) err_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      StFinish: begin
        bad = err_q | res_ovf | rem_ovf
            | (phase_q == PhLead) | (phase_q == PhSign)
            | ((phase_q == PhRem) & ~rem_dig_q)
            | (|res_mag[ACC_WIDTH-1:WIDTH]) | (|rem_mag[ACC_WIDTH-1:WIDTH]);
        if (neg_q) begin
          res_abs = ~res_mag[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        result_d    = bad ? '0 : res_abs;
        remainder_d = bad ? '0 : rem_mag[WIDTH-1:0];
        remain_d    = ~bad & (phase_q == PhRem);
        error_d     = bad;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= PhLead;
      shift_q     <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      rem_dig_q   <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      remain_q    <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      rem_dig_q   <= rem_dig_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      remain_q    <= remain_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign remain    = remain_q;
  assign error     = error_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_parser.sv
// Randomized bench for result_parser against a grammar-level reference parser.
module tb_result_parser;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] formatted;
  logic [20:0] result;
  logic [20:0] remainder;
  logic        remain;
  logic        error;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  result_parser #(.WIDTH(21)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .formatted (formatted),
    .result    (result),
    .remainder (remainder),
    .remain    (remain),
    .error     (error),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Recursive-descent view of the grammar: blank* [-] digit+ [r digit+].
  task automatic ref_parse(input logic [31:0] w, output logic [20:0] r, output logic [20:0] rm,
                           output logic rem, output logic err);
    int     nib[8];
    int     i;
    int     neg, nres, nrem;
    longint mag, rmag, lim;
    logic [63:0] t;
    for (int k = 0; k < 8; k++) nib[k] = int'((w >> (28 - 4 * k)) & 32'hF);
    i = 0;
    while (i < 8 && nib[i] == 15) i++;
    neg = 0;
    if (i < 8 && nib[i] == 14) begin neg = 1; i++; end
    mag = 0; nres = 0;
    while (i < 8 && nib[i] <= 9) begin mag = mag * 10 + nib[i]; nres++; i++; end
    rem = 1'b0; rmag = 0; nrem = 0;
    if (i < 8 && nib[i] == 10) begin
      rem = 1'b1; i++;
      while (i < 8 && nib[i] <= 9) begin rmag = rmag * 10 + nib[i]; nrem++; i++; end
    end
    lim = (neg != 0) ? 1048576 : 1048575;
    err = (i != 8) || (nres == 0) || (rem && nrem == 0) || (mag > lim) || (rmag > 1048575);
    if (err) begin
      r = '0; rm = '0; rem = 1'b0;
    end else begin
      t  = (neg != 0) ? 64'(-mag) : 64'(mag);
      r  = t[20:0];
      t  = 64'(rmag);
      rm = t[20:0];
    end
  endtask

  function automatic logic [31:0] gen_word();
    int mode, s, rp, b, nd, p;
    logic [3:0] n[8];
    logic [31:0] w;
    mode = int'($urandom_range(0, 3));
    if (mode == 0) return $urandom();
    s  = int'($urandom_range(0, 1));
    rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4)) : 0;
    b  = int'($urandom_range(0, 7 - s - rp));
    nd = 8 - b - s - rp;
    p  = 0;
    for (int k = 0; k < b; k++) begin n[p] = 4'hF; p++; end
    if (s == 1) begin n[p] = 4'hE; p++; end
    for (int k = 0; k < nd; k++) begin n[p] = 4'($urandom_range(0, 9)); p++; end
    if (rp > 0) begin
      n[p] = 4'hA; p++;
      for (int k = 1; k < rp; k++) begin n[p] = 4'($urandom_range(0, 9)); p++; end
    end
    if (mode == 3) n[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
    w = '0;
    for (int k = 0; k < 8; k++) w = {w[27:0], n[k]};
    return w;
  endfunction

  task automatic parse_and_check(input logic [31:0] w, input string tag);
    int cyc;
    logic [20:0] er, erm;
    logic        erem, eerr;
    ref_parse(w, er, erm, erem, eerr);
    @(negedge clock);
    formatted = w;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clock);
      #1 cyc++;
    end
    check_eq({tag, ".latency"}, 32'(cyc), 32'd9);
    check_eq({tag, ".result"}, 32'(result), 32'(er));
    check_eq({tag, ".remainder"}, 32'(remainder), 32'(erm));
    check_eq({tag, ".remain"}, 32'(remain), 32'(erem));
    check_eq({tag, ".error"}, 32'(error), 32'(eerr));
    check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] dir_words[11] = '{32'hFFFF1234, 32'hFFE42A03, 32'hF1048576, 32'hE1048576,
                                 32'hF1048575, 32'hFF12F345, 32'hFFFFFFFF, 32'hFFFF12AF,
                                 32'hFF1E2345, 32'hFFFF1B23, 32'hFFFFFFF0};

  initial begin
    int dones, first, second, cyc;
    reset     = 1'b1;
    start     = 1'b0;
    formatted = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst.result", 32'(result), 32'd0);
    check_eq("rst.remainder", 32'(remainder), 32'd0);
    check_eq("rst.remain", 32'(remain), 32'd0);
    check_eq("rst.error", 32'(error), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    reset = 1'b0;

    // Known answers, independent of the reference model.
    parse_and_check(32'hFFFF1234, "tp_pos");
    check_eq("tp_pos.kr", 32'(result), 32'h0004D2);
    parse_and_check(32'hFFE42A03, "tp_neg");
    check_eq("tp_neg.kr", 32'(result), 32'h1FFFD6);
    check_eq("tp_neg.krm", 32'(remainder), 32'd3);
    parse_and_check(32'hE1048576, "tp_min");
    check_eq("tp_min.kr", 32'(result), 32'h100000);
    parse_and_check(32'hF1048576, "tp_ovf");
    check_eq("tp_ovf.kerr", 32'(error), 32'd1);
    parse_and_check(32'hFFFF12AF, "tp_rblank");
    check_eq("tp_rblank.kerr", 32'(error), 32'd1);

    for (int i = 0; i < 11; i++) parse_and_check(dir_words[i], $sformatf("dir%0d", i));

    // Start re-pulsed mid-parse must be ignored.
    @(negedge clock);
    formatted = 32'hFFFF0777;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    dones = 0; first = -1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) begin formatted = 32'hFFFF0001; start = 1'b1; end
      else start = 1'b0;
      @(posedge clock);
      #1;
      if (done) begin dones++; if (first < 0) first = c; end
    end
    start = 1'b0;
    check_eq("repulse.dones", 32'(dones), 32'd1);
    check_eq("repulse.latency", 32'(first), 32'd9);
    check_eq("repulse.result", 32'(result), 32'd777);

    // Reset in cycle 5 of a parse aborts it with no done.
    @(negedge clock);
    formatted = 32'hFFFFE123;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check_eq("abort.result", 32'(result), 32'd0);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.error", 32'(error), 32'd0);
    dones = 0;
    repeat (12) begin @(posedge clock); #1; if (done) dones++; end
    check_eq("abort.dones", 32'(dones), 32'd0);
    parse_and_check(32'hFFFFFFF0, "after_abort");
    check_eq("after_abort.kr", 32'(result), 32'd0);
    check_eq("after_abort.kerr", 32'(error), 32'd0);

    // Reset and start together: start is dropped.
    @(negedge clock);
    reset = 1'b1; start = 1'b1; formatted = 32'hFFFF0001;
    @(posedge clock);
    #1 begin reset = 1'b0; start = 1'b0; end
    check_eq("rst_start.busy", 32'(busy), 32'd0);
    dones = 0;
    repeat (12) begin @(posedge clock); #1; if (done) dones++; end
    check_eq("rst_start.dones", 32'(dones), 32'd0);

    // Start held high re-triggers the cycle after done.
    @(negedge clock);
    formatted = 32'hFFFF0042;
    start     = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock);
      #1;
      if (done) begin if (first < 0) first = c; else if (second < 0) second = c; end
    end
    start = 1'b0;
    check_eq("held.first", 32'(first), 32'd9);
    check_eq("held.second", 32'(second), 32'd19);
    check_eq("held.result", 32'(result), 32'd42);
    cyc = 0;
    while (busy && cyc < 20) begin @(posedge clock); #1 cyc++; end
    check_eq("held.drain", 32'(busy), 32'd0);

    for (int i = 0; i < 200; i++) parse_and_check(gen_word(), $sformatf("rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
